// File: rtl/dual_digit_display.sv
// Two-digit multiplexed seven-segment driver: shadow-captures two nibbles and
// scans them onto a shared active-low segment bus with a dead-time gap per digit.
module dual_digit_display #(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 2,
  parameter bit          LZ_BLANK     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din_left,
  input  logic [3:0] din_right,
  input  logic       load,
  input  logic       blink,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {LEFT, GAP_L, RIGHT, GAP_R} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [FRM_W-1:0] frm_cnt_q;
  logic             ph_q;
  logic [3:0]       sh_l_q, sh_r_q;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Blink only gates the anodes; segments stay decoded so un-blinking is glitch-free.
  always_comb begin
    seg_d = '1;
    an_d  = '1;
    if (!blank) begin
      case (state_q)
        LEFT: begin
          if (!(LZ_BLANK && (sh_l_q == 4'd0))) begin
            seg_d = dec(sh_l_q);
            an_d  = 2'b10;
          end
        end
        RIGHT: begin
          seg_d = dec(sh_r_q);
          an_d  = 2'b01;
        end
        default: ;
      endcase
    end
    if (blink && ph_q) an_d = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LEFT;
      div_cnt_q <= '0;
      frm_cnt_q <= '0;
      ph_q      <= 1'b0;
      sh_l_q    <= '0;
      sh_r_q    <= '0;
      seg_q     <= '1;
      an_q      <= '1;
    end else begin
      if (load) begin
        sh_l_q <= din_left;
        sh_r_q <= din_right;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      case (state_q)
        LEFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            state_q   <= GAP_L;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        GAP_L: state_q <= RIGHT;
        RIGHT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            state_q   <= GAP_R;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        GAP_R: state_q <= LEFT;
      endcase
      if (!blink) begin
        frm_cnt_q <= '0;
        ph_q      <= 1'b0;
      end else if (state_q == GAP_R) begin
        if (frm_cnt_q == FRM_LAST) begin
          frm_cnt_q <= '0;
          ph_q      <= ~ph_q;
        end else begin
          frm_cnt_q <= frm_cnt_q + 1'b1;
        end
      end
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = (state_q == GAP_R);

endmodule

// File: tb/tb_dual_digit_display.sv
// Scoreboard bench for dual_digit_display: a frame-position model predicts each
// clock's outputs for a plain instance and a leading-zero-blanking instance.
module tb_dual_digit_display;

  localparam int R  = 4;
  localparam int BF = 2;
  localparam int FL = 2 * (R + 1);

  // Lit segments (active-high, {g,f,e,d,c,b,a}) for each hex glyph.
  localparam logic [6:0] LIT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst, load, blink, blank;
  logic [3:0] dl, dr;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic       fr0, fr1;

  always #5 clk = ~clk;

  dual_digit_display #(.REFRESH_DIV(R), .BLINK_FRAMES(BF), .LZ_BLANK(1'b0)) u0 (
    .clk(clk), .rst(rst), .din_left(dl), .din_right(dr), .load(load),
    .blink(blink), .blank(blank), .seg(seg0), .an(an0), .frame(fr0));

  dual_digit_display #(.REFRESH_DIV(R), .BLINK_FRAMES(BF), .LZ_BLANK(1'b1)) u1 (
    .clk(clk), .rst(rst), .din_left(dl), .din_right(dr), .load(load),
    .blink(blink), .blank(blank), .seg(seg1), .an(an1), .frame(fr1));

  int checks = 0;
  int errors = 0;

  // {frame, an, seg}
  typedef logic [9:0] exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Model: clock position within the frame, completed-frame count, blink phase.
  int         pos = 0;
  int         fc  = 0;
  bit         ph  = 1'b0;
  logic [3:0] shl = 4'd0;
  logic [3:0] shr = 4'd0;

  function automatic exp_t predict(input bit lz);
    logic [6:0] s;
    logic [1:0] a;
    s = 7'h7F;
    a = 2'b11;
    if (!blank) begin
      if (pos < R) begin
        if (!(lz && shl == 4'd0)) begin
          s = ~LIT[shl];
          a = 2'b10;
        end
      end else if (pos > R && pos < FL - 1) begin
        s = ~LIT[shr];
        a = 2'b01;
      end
    end
    if (blink && ph) a = 2'b11;
    return {1'b0, a, s};
  endfunction

  always @(posedge clk) begin
    exp_t e0, e1;
    if (!rst) begin
      e0  = {1'b0, 2'b11, 7'h7F};
      e1  = e0;
      pos = 0;
      fc  = 0;
      ph  = 1'b0;
      shl = 4'd0;
      shr = 4'd0;
    end else begin
      e0 = predict(1'b0);
      e1 = predict(1'b1);
      if (load) begin
        shl = dl;
        shr = dr;
      end
      if (!blink) begin
        fc = 0;
        ph = 1'b0;
      end else if (pos == FL - 1) begin
        fc = fc + 1;
        if (fc == BF) begin
          fc = 0;
          ph = ~ph;
        end
      end
      pos = (pos + 1) % FL;
    end
    e0[9] = (pos == FL - 1);
    e1[9] = (pos == FL - 1);
    q0.push_back(e0);
    q1.push_back(e1);
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  logic [1:0] prev0 = 2'b11;
  logic [1:0] prev1 = 2'b11;

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("seg0", seg0, e[6:0]);
      check("an0", {5'd0, an0}, {5'd0, e[8:7]});
      check("frame0", {6'd0, fr0}, {6'd0, e[9]});
      if (an0 != 2'b11 && prev0 != 2'b11)
        check("gap0", {5'd0, an0}, {5'd0, prev0});
      prev0 = an0;
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("seg1", seg1, e[6:0]);
      check("an1", {5'd0, an1}, {5'd0, e[8:7]});
      check("frame1", {6'd0, fr1}, {6'd0, e[9]});
      if (an1 != 2'b11 && prev1 != 2'b11)
        check("gap1", {5'd0, an1}, {5'd0, prev1});
      prev1 = an1;
    end
  end

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while (pos != target && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (pos != target) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", pos, target);
    end
  endtask

  task automatic pulse_load(input logic [3:0] l, input logic [3:0] r);
    dl   = l;
    dr   = r;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; blink = 1'b0; blank = 1'b0; dl = 4'd0; dr = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);

    pulse_load(4'd3, 4'd5);
    repeat (20) @(negedge clk);
    dl = 4'd4;
    repeat (20) @(negedge clk);
    pulse_load(4'd4, 4'd5);
    repeat (20) @(negedge clk);

    wait_pos(0);
    blink = 1'b1;
    repeat (90) @(negedge clk);
    blink = 1'b0;
    repeat (10) @(negedge clk);

    pulse_load(4'd0, 4'd4);
    repeat (20) @(negedge clk);
    pulse_load(4'hA, 4'd4);
    repeat (20) @(negedge clk);

    wait_pos(R + 3);
    rst = 1'b0; load = 1'b1; dl = 4'hF; dr = 4'hF;
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    repeat (20) @(negedge clk);

    pulse_load(4'd8, 4'd0);
    wait_pos(2);
    blank = 1'b1;
    repeat (25) @(negedge clk);
    blank = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      load = ($urandom % 4 == 0);
      dl   = 4'($urandom);
      dr   = 4'($urandom);
      if ($urandom % 50 == 0) blink = ~blink;
      if ($urandom % 40 == 0) blank = ~blank;
      rst  = ($urandom % 300 != 0);
      @(negedge clk);
    end

    rst = 1'b1; load = 1'b0; blink = 1'b0; blank = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_digit_display.md
# dual_digit_display

Two-digit multiplexed seven-segment display driver that sits directly downstream of the request/confirm entry system. It captures that system's `dout_left`/`dout_right` nibbles into shadow registers on a load strobe. It then time-multiplexes the two digits onto one shared active-low segment bus, with a dead-time gap between digits. Optional blinking and left-digit leading-zero suppression are provided for board use.

## Interface
- `REFRESH_DIV`, 4: clocks each digit is driven per scan slot (≥1).
- `BLINK_FRAMES`, 2: full scan frames per blink half-period (≥1).
- `LZ_BLANK`, 0: when 1, the left digit is blanked while its shadow value is 0.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `din_left` input 4: left nibble, connected to the upstream `dout_left`.
- `din_right` input 4: right nibble, connected to the upstream `dout_right`.
- `load` input 1: capture strobe; both nibbles are sampled on any edge where it is 1.
- `blink` input 1: enables blinking of both digits.
- `blank` input 1: forces all anodes off while it is 1.
- `seg` output 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- `an` output 2: active-low anodes; `an[1]` drives the left digit, `an[0]` the right digit.
- `frame` output 1: one-clock pulse on the last gap cycle of each frame.

## Operation
- Shadow registers `sh_l`/`sh_r`:
  - Load both input nibbles when `load`=1.
  - Otherwise hold their value.
- FSM states: `LEFT` → `GAP_L` → `RIGHT` → `GAP_R` → `LEFT`.
  - `LEFT`/`RIGHT` each last REFRESH_DIV cycles, timed by counter `div_cnt` running 0..REFRESH_DIV-1.
  - `GAP_L`/`GAP_R` each last exactly 1 cycle.
  - Frame length = 2·(REFRESH_DIV+1) clocks.
- Decode is full hex 0–F, active-low:
  - 0=1000000, 3=0110000, 4=0011001, 5=0010010, 8=0000000, A=0001000, F=0001110.
  - Blank pattern = 1111111.
- Registered outputs, computed each edge from the current state:
  - In `LEFT`: `an`=10 and `seg`=dec(`sh_l`); but `seg`=1111111 and `an`=11 if LZ_BLANK=1 and `sh_l`=0.
  - In `RIGHT`: `an`=01 and `seg`=dec(`sh_r`).
  - In either gap: `an`=11 and `seg`=1111111.
- Blink:
  - `frm_cnt` counts completed frames (it advances when `GAP_R` ends).
  - Phase `ph` toggles each time `frm_cnt` reaches BLINK_FRAMES-1; `frm_cnt` then wraps to 0.
  - If `blink`=1 and `ph`=1, `an` is forced to 11; `seg` is still decoded.
  - While `blink`=0, `ph` and `frm_cnt` are held at 0, so a new blink request always starts with the digits visible.
- `blank`=1:
  - Forces `an`=11 and `seg`=1111111.
  - The FSM, counters and shadow registers keep running.
- Reset (`rst`=0 at an edge):
  - FSM goes to `LEFT`, with `div_cnt`=0, `frm_cnt`=0, `ph`=0, `sh_l`=`sh_r`=0.
  - Outputs become `an`=11, `seg`=1111111, `frame`=0.
  - Reset overrides `load`, `blink` and `blank`, and takes effect mid-frame with no completion of the current slot.

## Timing
- Output latency is 1 clock from FSM state and shadow contents to `seg`/`an`.
- First edge after `rst` returns high:
  - Outputs reflect `LEFT`, so `an`=10 for REFRESH_DIV cycles.
  - This is followed by 1 cycle of `an`=11.
- Load:
  - A load at edge k updates the shadow registers at edge k.
  - `seg` shows the new value from edge k+1, provided the matching digit slot is active at k+1.
  - A load during a gap or during the other digit's slot appears at that digit's next slot.
- `load` held high continuously makes the display follow its inputs with 1-clock shadow delay.
- `frame`:
  - Asserted during the cycle the FSM is in `GAP_R`, computed combinationally from state.
  - This is the only unregistered output.
- Blink half-period = BLINK_FRAMES·2·(REFRESH_DIV+1) clocks.
- `blank` and `blink` are applied in the same registered output stage, so each takes effect 1 clock after it changes.
- No digit's anode is ever active on two consecutive slots without an intervening all-off gap cycle; the verification bench checks this as an invariant.

## Test plan
- Reset then scan:
  - Stimulus: `rst`=0 for 2 clocks, then 1, with REFRESH_DIV=4.
  - Required: `an` = 11 during reset, then 10×4, 11, 01×4, 11, repeating; `seg`=1000000 in both digit slots.
- Load capture:
  - Stimulus: `load`=1 for 1 clock with `din_left`=3 and `din_right`=5.
  - Required: left slots show 0110000 and right slots show 0010010.
  - A later change of `din_left` to 4 with `load`=0 leaves the display unchanged; a subsequent load shows 0011001.
- Blink:
  - Stimulus: `blink`=1, BLINK_FRAMES=2, REFRESH_DIV=4.
  - Required: 2 frames (20 clocks) visible, then 20 clocks with `an`=11, alternating.
  - Deasserting `blink` restores visibility within 1 clock.
- Leading-zero suppression:
  - Stimulus: LZ_BLANK=1, load left=0 and right=4.
  - Required: left slot gives `an`=11 and `seg`=1111111; right slot gives 0011001.
  - Loading left=A then shows 0001000 in the left slot.
- Reset mid-frame with simultaneous load:
  - Stimulus: assert `rst`=0 in `RIGHT` slot cycle 2 with `load`=1 and `din`=F/F.
  - Required: shadow registers = 0 and `an`=11.
  - After release, the scan restarts at `LEFT` with 1000000.
- Gap invariant and `blank`:
  - Stimulus: `blank`=1 mid-slot.
  - Required: `an`=11 from the next clock and `frame` keeps pulsing every 10 clocks.
  - On release, the display resumes in the correct phase.
